// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the pipeline memory-port arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_D_BUSY,
        ARB_I_BUSY
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding pipeline and memory.
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ready;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_valid;

    logic                  stall_f;
    logic                  stall_m;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid,
        output stall_f, stall_m
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_valid,
        input  stall_f, stall_m
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch (I) and the
// MEM stage (D). D wins by default; a starvation counter forces an I grant after
// STARVE_MAX consecutive D grants taken while I was waiting.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                d_elig;
    logic                i_elig;

    // Grant selection in IDLE, completion handling in the busy states, starvation bookkeeping.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        d_elig       = bus.d_req & ~d_ready_q;
        i_elig       = bus.i_req & ~i_ready_q;

        case (state_q)
            ARB_IDLE: begin
                if (i_elig && (!d_elig || starve_cnt_q == STARVE_LIM)) begin
                    state_d      = ARB_I_BUSY;
                    starve_cnt_d = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = bus.i_addr;
                    mem_wdata_d  = '0;
                end else if (d_elig) begin
                    state_d      = ARB_D_BUSY;
                    if (i_elig) begin
                        starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 1'b1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.d_we;
                    mem_be_d     = bus.d_be;
                    mem_addr_d   = bus.d_addr;
                    mem_wdata_d  = bus.d_wdata;
                end
            end
            ARB_D_BUSY: begin
                if (bus.mem_valid) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            ARB_I_BUSY: begin
                if (bus.mem_valid) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    i_ready_d = 1'b1;
                    i_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.stall_f   = bus.i_req & ~i_ready_q;
    assign bus.stall_m   = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// reset/starvation sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int STARVE = 4;
    localparam int NV     = 21;
    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_I    = 2;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        i_ready;
        logic        d_ready;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        logic        stall_f;
        logic        stall_m;
    } obs_t;

    typedef struct packed {
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        i_req;
        logic [31:0] i_addr;
        logic        mem_valid;
        logic [31:0] mem_rdata;
    } stim_t;

    typedef struct packed {
        stim_t stim;
        obs_t  exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    obs_t m;
    int   owner;
    int   waits;
    int   age;
    int   lat;
    int   max_lat;

    vec_t vecs [NV];

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic dr, logic dwe, logic [3:0] dbe, logic [31:0] da, logic [31:0] dwd,
                                logic ir, logic [31:0] ia, logic mv, logic [31:0] mrd,
                                logic emr, logic emwe, logic [3:0] embe, logic [31:0] ema, logic [31:0] emwd,
                                logic eir, logic edr, logic [31:0] eird, logic [31:0] edrd, logic esf, logic esm);
        vec_t v;
        v.stim = '{dr, dwe, dbe, da, dwd, ir, ia, mv, mrd};
        v.exp  = '{emr, emwe, embe, ema, emwd, eir, edr, eird, edrd, esf, esm};
        return v;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.mem_req   = bus_if.mem_req;
        o.mem_we    = bus_if.mem_we;
        o.mem_be    = bus_if.mem_be;
        o.mem_addr  = bus_if.mem_addr;
        o.mem_wdata = bus_if.mem_wdata;
        o.i_ready   = bus_if.i_ready;
        o.d_ready   = bus_if.d_ready;
        o.i_rdata   = bus_if.i_rdata;
        o.d_rdata   = bus_if.d_rdata;
        o.stall_f   = bus_if.stall_f;
        o.stall_m   = bus_if.stall_m;
        return o;
    endfunction

    function automatic obs_t mask(obs_t o);
        obs_t r = o;
        if (!r.mem_req) begin
            r.mem_we   = 1'b0;
            r.mem_be   = '0;
            r.mem_addr = '0;
        end
        if (!r.mem_req || !r.mem_we) r.mem_wdata = '0;
        return r;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("mreq=%0b we=%0b be=%h addr=%h wd=%h irdy=%0b drdy=%0b ird=%h drd=%h sf=%0b sm=%0b",
                         o.mem_req, o.mem_we, o.mem_be, o.mem_addr, o.mem_wdata,
                         o.i_ready, o.d_ready, o.i_rdata, o.d_rdata, o.stall_f, o.stall_m);
    endfunction

    task automatic check_output(input string name, input obs_t exp, input bit full);
        obs_t act = sample_dut();
        obs_t e   = exp;
        if (!full) begin
            act = mask(act);
            e   = mask(e);
        end
        total++;
        if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(e));
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        bus_if.d_req     = s.d_req;
        bus_if.d_we      = s.d_we;
        bus_if.d_be      = s.d_be;
        bus_if.d_addr    = s.d_addr;
        bus_if.d_wdata   = s.d_wdata;
        bus_if.i_req     = s.i_req;
        bus_if.i_addr    = s.i_addr;
        bus_if.mem_valid = s.mem_valid;
        bus_if.mem_rdata = s.mem_rdata;
    endtask

    task automatic model_reset();
        m     = '0;
        owner = OWN_NONE;
        waits = 0;
        age   = 0;
        lat   = 1;
    endtask

    // Transaction view: one owner at a time; a waiting fetch is forced in after STARVE data wins.
    task automatic model_step();
        bit d_want, i_want, granted;
        d_want  = bus_if.d_req && !m.d_ready;
        i_want  = bus_if.i_req && !m.i_ready;
        granted = 1'b0;
        m.i_ready = 1'b0;
        m.d_ready = 1'b0;
        if (owner == OWN_NONE) begin
            if (i_want && (!d_want || waits >= STARVE)) begin
                owner = OWN_I;
                waits = 0;
                m.mem_req = 1'b1; m.mem_we = 1'b0; m.mem_be = 4'hF;
                m.mem_addr = bus_if.i_addr; m.mem_wdata = '0;
                granted = 1'b1;
            end else if (d_want) begin
                owner = OWN_D;
                waits = i_want ? ((waits < STARVE) ? waits + 1 : STARVE) : 0;
                m.mem_req = 1'b1; m.mem_we = bus_if.d_we; m.mem_be = bus_if.d_be;
                m.mem_addr = bus_if.d_addr; m.mem_wdata = bus_if.d_wdata;
                granted = 1'b1;
            end
        end else if (bus_if.mem_valid) begin
            if (owner == OWN_D) begin
                m.d_ready = 1'b1;
                if (!m.mem_we) m.d_rdata = bus_if.mem_rdata;
            end else begin
                m.i_ready = 1'b1;
                m.i_rdata = bus_if.mem_rdata;
            end
            owner = OWN_NONE;
            m.mem_req = 1'b0;
        end
        if (granted) begin
            age = 0;
            lat = $urandom_range(1, max_lat);
        end else if (m.mem_req) begin
            age++;
        end
    endtask

    function automatic obs_t model_exp();
        obs_t o = m;
        o.stall_f = bus_if.i_req & ~m.i_ready;
        o.stall_m = bus_if.d_req & ~m.d_ready;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    initial begin
        stim_t s;
        obs_t  act;
        logic  prev_mreq;
        bit    seen_i;
        int    d_before_i;
        int    round;

        rst = 1'b1;
        s = '0;
        apply_stimulus(s);
        max_lat = 1;
        model_reset();

        vecs[0]  = mk(1,0,4'hF,32'h40,0,        0,0,      0,0,            0,0,0,0,0,                      0,0,0,0,                      0,1);
        vecs[1]  = mk(1,0,4'hF,32'h40,0,        0,0,      0,0,            1,0,4'hF,32'h40,0,              0,0,0,0,                      0,1);
        vecs[2]  = mk(1,0,4'hF,32'h40,0,        0,0,      1,32'hDEADBEEF, 1,0,4'hF,32'h40,0,              0,0,0,0,                      0,1);
        vecs[3]  = mk(1,0,4'hF,32'h40,0,        0,0,      0,0,            0,0,0,0,0,                      0,1,0,32'hDEADBEEF,           0,0);
        vecs[4]  = mk(0,0,0,0,0,                0,0,      0,0,            0,0,0,0,0,                      0,0,0,32'hDEADBEEF,           0,0);
        vecs[5]  = mk(1,1,4'h3,32'h80,32'h1234ABCD, 0,0,  0,0,            0,0,0,0,0,                      0,0,0,32'hDEADBEEF,           0,1);
        vecs[6]  = mk(1,1,4'h3,32'h80,32'h1234ABCD, 0,0,  0,0,            1,1,4'h3,32'h80,32'h1234ABCD,   0,0,0,32'hDEADBEEF,           0,1);
        vecs[7]  = mk(1,1,4'h3,32'h80,32'h1234ABCD, 0,0,  1,32'h55555555, 1,1,4'h3,32'h80,32'h1234ABCD,   0,0,0,32'hDEADBEEF,           0,1);
        vecs[8]  = mk(1,1,4'h3,32'h80,32'h1234ABCD, 0,0,  0,0,            0,0,0,0,0,                      0,1,0,32'hDEADBEEF,           0,0);
        vecs[9]  = mk(0,0,0,0,0,                0,0,      0,0,            0,0,0,0,0,                      0,0,0,32'hDEADBEEF,           0,0);
        vecs[10] = mk(1,0,4'hF,32'h100,0,       1,32'h200, 0,0,           0,0,0,0,0,                      0,0,0,32'hDEADBEEF,           1,1);
        vecs[11] = mk(1,0,4'hF,32'h100,0,       1,32'h200, 0,0,           1,0,4'hF,32'h100,0,             0,0,0,32'hDEADBEEF,           1,1);
        vecs[12] = mk(1,0,4'hF,32'h100,0,       1,32'h200, 1,32'hAAAA0001, 1,0,4'hF,32'h100,0,            0,0,0,32'hDEADBEEF,           1,1);
        vecs[13] = mk(1,0,4'hF,32'h100,0,       1,32'h200, 0,0,           0,0,0,0,0,                      0,1,0,32'hAAAA0001,           1,0);
        vecs[14] = mk(0,0,0,0,0,                1,32'h200, 0,0,           1,0,4'hF,32'h200,0,             0,0,0,32'hAAAA0001,           1,0);
        vecs[15] = mk(0,0,0,0,0,                1,32'h200, 1,32'hBBBB0002, 1,0,4'hF,32'h200,0,            0,0,0,32'hAAAA0001,           1,0);
        vecs[16] = mk(0,0,0,0,0,                1,32'h200, 0,0,           0,0,0,0,0,                      1,0,32'hBBBB0002,32'hAAAA0001, 0,0);
        vecs[17] = mk(0,0,0,0,0,                0,0,      0,0,            0,0,0,0,0,                      0,0,32'hBBBB0002,32'hAAAA0001, 0,0);
        vecs[18] = mk(0,0,0,0,0,                0,0,      1,32'h12345678, 0,0,0,0,0,                      0,0,32'hBBBB0002,32'hAAAA0001, 0,0);
        vecs[19] = mk(0,0,0,0,0,                0,0,      0,0,            0,0,0,0,0,                      0,0,32'hBBBB0002,32'hAAAA0001, 0,0);
        vecs[20] = mk(0,0,0,0,0,                0,0,      0,0,            0,0,0,0,0,                      0,0,32'hBBBB0002,32'hAAAA0001, 0,0);

        // power-on reset values
        #12;
        check_output("reset", '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // directed vectors: load, store, simultaneous requests, spurious mem_valid
        for (int k = 0; k < NV; k++) begin
            apply_stimulus(vecs[k].stim);
            #2;
            check_output($sformatf("vec%0d", k), vecs[k].exp, 1'b0);
            tick();
        end

        // reset in the middle of a data access
        s = '0;
        s.d_req = 1'b1; s.d_be = 4'hF; s.d_addr = 32'h300;
        apply_stimulus(s);
        #2;
        check_output("rst_grant", model_exp(), 1'b0);
        tick();
        apply_stimulus(s);
        #2;
        check_output("rst_busy", model_exp(), 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_output("rst_async", model_exp(), 1'b1);
        #1;
        rst = 1'b0;
        s = '0;
        apply_stimulus(s);
        tick();
        s.mem_valid = 1'b1; s.mem_rdata = 32'hCAFEF00D;
        apply_stimulus(s);
        #2;
        check_output("rst_late_valid", model_exp(), 1'b1);
        tick();
        s = '0;
        apply_stimulus(s);
        for (int k = 0; k < 2; k++) begin
            #2;
            check_output("rst_no_ready", model_exp(), 1'b1);
            tick();
        end

        // starvation: data re-requests at every ready, fetch absent only in data-ready cycles
        max_lat    = 1;
        prev_mreq  = 1'b0;
        seen_i     = 1'b0;
        d_before_i = 0;
        round      = 0;
        for (int c = 0; c < 30; c++) begin
            if (m.d_ready) round++;
            s = '0;
            s.d_req     = 1'b1;
            s.d_be      = 4'hF;
            s.d_addr    = 32'h1000 + 32'(round * 4);
            s.i_req     = !m.d_ready;
            s.i_addr    = 32'h2000;
            s.mem_valid = m.mem_req && (age == lat);
            s.mem_rdata = $urandom;
            apply_stimulus(s);
            #2;
            check_output("starve", model_exp(), 1'b0);
            act = sample_dut();
            if (act.mem_req && !prev_mreq && !seen_i) begin
                if (act.mem_addr == 32'h2000) seen_i = 1'b1;
                else d_before_i++;
            end
            prev_mreq = act.mem_req;
            tick();
        end
        total++;
        if (!seen_i || d_before_i != STARVE) begin
            bad++;
            $display("[TB] FAIL starve_count: got %0d data grants before fetch (fetch seen=%0b), expected %0d",
                     d_before_i, seen_i, STARVE);
        end

        // randomized traffic with variable memory latency and spurious mem_valid
        max_lat = 3;
        s = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!s.d_req || m.d_ready) begin
                s.d_req   = ($urandom_range(0, 3) != 0);
                s.d_we    = $urandom_range(0, 1) == 1;
                s.d_be    = 4'($urandom_range(0, 15));
                s.d_addr  = $urandom & 32'hFFFC;
                s.d_wdata = $urandom;
            end
            if (!s.i_req || m.i_ready) begin
                s.i_req  = ($urandom_range(0, 1) == 1);
                s.i_addr = $urandom & 32'hFFFC;
            end
            if (m.mem_req) s.mem_valid = (age == lat);
            else           s.mem_valid = ($urandom_range(0, 7) == 0);
            s.mem_rdata = $urandom;
            apply_stimulus(s);
            #2;
            check_output("random", model_exp(), 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
